// File: rtl/bridge_req_arbiter_if.sv
// Request/response and downstream bridge bundle for bridge_req_arbiter.
// slave = arbiter view, master = requester/bridge-model view.
interface bridge_req_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_wr;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_rdata;
  logic [31:0]           bridge_addr;
  logic [31:0]           bridge_wr_data;
  logic                  bridge_wr;
  logic                  bridge_rd;
  logic [31:0]           bridge_rd_data;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, bridge_rd_data,
    output req_ready, resp_valid, resp_rdata,
           bridge_addr, bridge_wr_data, bridge_wr, bridge_rd
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, bridge_rd_data,
    input  req_ready, resp_valid, resp_rdata,
           bridge_addr, bridge_wr_data, bridge_wr, bridge_rd
  );
endinterface

// File: rtl/bridge_req_arbiter.sv
// Round-robin arbiter sharing one bridge port among NUM_REQ requesters, one transaction at a time.
// Define BRIDGE_ARB_FIXED_PRIO_EN for strict fixed priority (requester 0 highest). bus NUM_REQ must match.
module bridge_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1
) (
  input logic                  clk,
  input logic                  reset_n,
  bridge_req_arbiter_if.slave  bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] RD_LAT = 4'(RD_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] grant_idx;
  logic          grant_found;
  logic          accept;
  logic [PW-1:0] base;
  logic [PW-1:0] owner_reg;
  logic          wr_reg;
  logic [31:0]   addr_reg, wdata_reg, rdata_reg;
  logic [3:0]    cnt_reg, cnt_next;
  logic          capture;
  logic [31:0]   addr_arr  [NUM_REQ];
  logic [31:0]   wdata_arr [NUM_REQ];

`ifdef BRIDGE_ARB_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [PW-1:0] ptr_reg;
  assign base = ptr_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_reg <= '0;
    end else if (accept) begin
      ptr_reg <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  // Search base, base+1, ... ; iterating downwards lets the nearest candidate win.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = (int'(base) + i) % NUM_REQ;
      if (bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(cand);
      end
    end
  end

  // reset_n gates the accept so req_ready stays low while reset is held.
  assign accept = (state_reg == IDLE) && reset_n && grant_found;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]       = bus.req_addr[gi*32 +: 32];
      assign wdata_arr[gi]      = bus.req_wdata[gi*32 +: 32];
      assign bus.req_ready[gi]  = accept && (grant_idx == PW'(gi));
      assign bus.resp_valid[gi] = (state_reg == RESP) && (owner_reg == PW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    capture       = 1'b0;
    bus.bridge_wr = 1'b0;
    bus.bridge_rd = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        bus.bridge_wr = wr_reg;
        bus.bridge_rd = !wr_reg;
        cnt_next      = 4'd1;
        state_next    = wr_reg ? RESP : WAIT_RD;
      end
      WAIT_RD: begin
        if (cnt_reg == RD_LAT) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      wr_reg    <= 1'b0;
      owner_reg <= '0;
      rdata_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      cnt_reg <= cnt_next;
      if (accept) begin
        addr_reg  <= addr_arr[grant_idx];
        wdata_reg <= wdata_arr[grant_idx];
        wr_reg    <= bus.req_wr[grant_idx];
        owner_reg <= grant_idx;
      end
      if (capture) rdata_reg <= bus.bridge_rd_data;
    end
  end

  assign bus.bridge_addr    = addr_reg;
  assign bus.bridge_wr_data = wdata_reg;
  assign bus.resp_rdata     = rdata_reg;
endmodule

// File: tb/tb_bridge_req_arbiter.sv
// Directed bench for bridge_req_arbiter: NUM_REQ=2, RD_LATENCY=3, bridge model returns data 3 cycles after rd.
module tb_bridge_req_arbiter;
  localparam int NREQ = 2;
  localparam int LAT  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] rd_dly = '0;
  int n_checks = 0;
  int n_pass = 0;

  bridge_req_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  bridge_req_arbiter #(.NUM_REQ(NREQ), .RD_LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Bridge model: read data valid exactly LAT cycles after the rd strobe, junk otherwise.
  always_ff @(posedge clk) rd_dly <= {rd_dly[1:0], bus.bridge_rd};
  assign bus.bridge_rd_data = rd_dly[2] ?
      ((bus.bridge_addr == 32'h8000_0004) ? 32'h1234_5678 : (bus.bridge_addr ^ 32'hA5A5_A5A5)) :
      32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after RESP.
  task automatic do_txn(input int who, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input string tag);
    logic [1:0] oh;
    logic done;
    int exp_k;
    oh    = 2'b01 << who;
    exp_k = wr ? 2 : 2 + LAT;
    bus.req_valid[who]          = 1'b1;
    bus.req_wr[who]             = wr;
    bus.req_addr[who*32 +: 32]  = addr;
    bus.req_wdata[who*32 +: 32] = wdata;
    #1 check({tag, "_ready"}, 32'(bus.req_ready), 32'(oh));
    @(negedge clk);
    bus.req_valid[who] = 1'b0;
    done = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      check({tag, "_addr"}, bus.bridge_addr, addr);
      check({tag, "_wdata"}, bus.bridge_wr_data, wdata);
      check({tag, "_wr"}, 32'(bus.bridge_wr), 32'(wr && k == 1));
      check({tag, "_rd"}, 32'(bus.bridge_rd), 32'(!wr && k == 1));
      if (bus.resp_valid != '0) begin
        done = 1'b1;
        check({tag, "_resp"}, 32'(bus.resp_valid), 32'(oh));
        check({tag, "_lat"}, 32'(k), 32'(exp_k));
        check({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
        $display("txn %s: req%0d %s addr=0x%08h wdata=0x%08h rdata=0x%08h cycles=%0d",
                 tag, who, wr ? "WR" : "RD", addr, wdata, bus.resp_rdata, k);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int grants [4];
    int exp_g [4];
    int ng;
    int g;
    logic seen;
`ifdef BRIDGE_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    bus.req_valid = 2'b11;
    bus.req_wr    = 2'b11;
    bus.req_addr  = {32'h0000_0020, 32'h0000_0010};
    bus.req_wdata = {32'h0000_0022, 32'h0000_0011};

    // Reset held 3 cycles with both requesters valid
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_wr", 32'(bus.bridge_wr), 32'd0);
    check("rst_rd", 32'(bus.bridge_rd), 32'd0);
    check("rst_addr", bus.bridge_addr, 32'd0);
    check("rst_wdata", bus.bridge_wr_data, 32'd0);
    check("rst_resp", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    reset_n = 1'b1;
    #1 check("rst_first_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid[1] = 1'b0;
    do_txn(0, 1'b1, 32'h0000_0010, 32'h0000_0011, 32'h0, "rst_wr0");

    do_txn(0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, "single_wr");
    do_txn(1, 1'b0, 32'h8000_0004, 32'h0000_0000, 32'h1234_5678, "single_rd");

    // Contention: both keep valid high for 4 grants
    bus.req_wr    = 2'b11;
    bus.req_addr  = {32'hB000_0000, 32'hA000_0000};
    bus.req_wdata = {32'h0000_0002, 32'h0000_0001};
    bus.req_valid = 2'b11;
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      #1;
      if (bus.req_ready != '0) begin
        g = bus.req_ready[1] ? 1 : 0;
        grants[ng] = g;
        ng++;
        @(negedge clk);
        check("cont_addr", bus.bridge_addr, (g == 1) ? 32'hB000_0000 : 32'hA000_0000);
        check("cont_wdata", bus.bridge_wr_data, (g == 1) ? 32'h2 : 32'h1);
        $display("txn cont: grant %0d -> req%0d", ng, g);
      end else begin
        @(negedge clk);
      end
    end
    bus.req_valid = 2'b00;
    check("cont_ngrants", 32'(ng), 32'd4);
    for (int i = 0; i < 4 && i < ng; i++) check("cont_order", 32'(grants[i]), 32'(exp_g[i]));
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (bus.resp_valid != '0) seen = 1'b1;
    end
    check("cont_last_resp", 32'(seen), 32'd1);
    check("cont_rdata_held", bus.resp_rdata, 32'h1234_5678);
    @(negedge clk);

    // Reset during WAIT_RD aborts the read
    bus.req_wr[0]       = 1'b0;
    bus.req_addr[31:0]  = 32'h2000_0000;
    bus.req_wdata[31:0] = 32'h0;
    bus.req_valid[0]    = 1'b1;
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_resp", 32'(bus.resp_valid), 32'd0);
    check("midrst_rd", 32'(bus.bridge_rd), 32'd0);
    check("midrst_wr", 32'(bus.bridge_wr), 32'd0);
    check("midrst_addr", bus.bridge_addr, 32'd0);
    check("midrst_wdata", bus.bridge_wr_data, 32'd0);
    check("midrst_rdata", bus.resp_rdata, 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("midrst_resp2", 32'(bus.resp_valid), 32'd0);
    reset_n = 1'b1;
    $display("txn midrst: read aborted by reset");
    do_txn(0, 1'b0, 32'h2000_0000, 32'h0, 32'h85A5_A5A5, "rd_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
